// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the register-file side of the core: register address
// width, multiply/divide opcodes and the muldiv sequencer states.
package muldiv_unit_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one bit per cycle, fixed latency,
// result written back to the register file through RESULT/AD_OUT/WR.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [1:0]        OP,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [REG_AW-1:0] AD_IN,
    output logic              BUSY,
    output logic              DONE,
    output logic [WIDTH-1:0]  RESULT,
    output logic [REG_AW-1:0] AD_OUT,
    output logic              WR
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    op_e                 op_q;
    logic [REG_AW-1:0]   ad_q;
    logic [WIDTH-1:0]    opd_q;
    logic [2*WIDTH-1:0]  acc_q, acc_step;
    logic                accept, last, is_div, take_hi;

    assign accept  = (state_q == S_IDLE) && START;
    assign last    = (cnt_q == CW'(WIDTH));
    assign is_div  = (op_q == OP_DIVU) || (op_q == OP_REMU);
    assign take_hi = (op_q == OP_MULHU) || (op_q == OP_REMU);

    assign BUSY = (state_q != S_IDLE);
    assign DONE = (state_q == S_FIN);
    assign WR   = DONE;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_RUN;
            S_RUN:   if (last)  state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Shared accumulator: {hi, lo} is {partial sum, multiplier} for multiply
    // and {remainder, quotient} for divide.
    logic [WIDTH:0]   sum, r_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        r_sh = acc_q[2*WIDTH-1:WIDTH-1];
        ge   = (r_sh >= {1'b0, opd_q});
        diff = r_sh[WIDTH-1:0] - opd_q;
        if (is_div) acc_step = {(ge ? diff : r_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
        else        acc_step = {sum, acc_q[WIDTH-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            RESULT  <= '0;
            AD_OUT  <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                cnt_q <= '0;
            else if (state_q == S_RUN && !last)
                cnt_q <= cnt_q + 1'b1;
            if (state_q == S_RUN && last) begin
                RESULT <= take_hi ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
                AD_OUT <= ad_q;
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge CLK) begin
        if (accept) begin
            op_q  <= op_e'(OP);
            ad_q  <= AD_IN;
            opd_q <= OP[1] ? B : A;
            acc_q <= {{WIDTH{1'b0}}, (OP[1] ? A : B)};
        end else if (state_q == S_RUN && !last) begin
            acc_q <= acc_step;
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width; only 32 is required to be supported.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port START, input, 1 bit: request a new operation; accepted only in IDLE.
REQ-005 SHALL have port OP, input, 2 bits: 00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU.
REQ-006 SHALL have ports A and B, input, WIDTH bits each: operands taken from register-file RS1 and RS2.
REQ-007 SHALL have port AD_IN, input, 5 bits: destination register index.
REQ-008 SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-009 SHALL have port DONE, output, 1 bit: one-cycle pulse when RESULT is valid.
REQ-010 SHALL have port RESULT, output, WIDTH bits: drives register-file RD.
REQ-011 SHALL have port AD_OUT, output, 5 bits: drives register-file AD.
REQ-012 SHALL have port WR, output, 1 bit: drives register-file WR; identical to DONE.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, RUN, FIN.
- IDLE -> RUN on START=1.
- RUN -> FIN after WIDTH iterations.
- FIN -> IDLE unconditionally after one cycle.
REQ-014 SHALL capture OP, A, B and AD_IN on the accepting edge; later changes on those inputs SHALL NOT affect the operation in flight.
REQ-015 SHALL ignore START while BUSY=1; no queuing.
REQ-016 SHALL perform MUL and MULHU as an unsigned shift-add, one multiplier bit per cycle, into a 2*WIDTH-bit product.
- MUL returns product[WIDTH-1:0].
- MULHU returns product[2*WIDTH-1:WIDTH].
REQ-017 SHALL perform DIVU and REMU as restoring division, one quotient bit per cycle.
- DIVU returns the quotient; REMU returns the remainder.
REQ-018 SHALL handle B=0 for division as follows: DIVU returns all-ones; REMU returns A. No exception output.
REQ-019 SHALL use a fixed latency: START accepted at edge 0; DONE, WR, RESULT and AD_OUT valid during the cycle after edge WIDTH+1 (33 cycles for WIDTH=32), independent of operand values.
REQ-020 SHALL drive RESULT and AD_OUT as registered values, held stable from FIN until the next accepted START.
REQ-021 SHALL assert WR even when AD_OUT=0; the register file guarantees x0 reads as zero.
REQ-022 SHALL use an iteration counter of clog2(WIDTH)+1 bits that wraps to 0 on entry to RUN; it SHALL NOT be observable externally.
REQ-023 SHALL treat START asserted in the FIN cycle as ignored; a new START is accepted from the following IDLE cycle.

Reset
REQ-024 SHALL force the following on RST_N=0, asynchronously: state IDLE, BUSY=0, DONE=0, WR=0, RESULT=0, AD_OUT=0, counter=0.
REQ-025 SHALL abandon any operation interrupted by reset mid-RUN or in FIN, with no WR pulse after release.
REQ-026 SHALL make START effective on the first rising edge at which RST_N=1.

Structure
REQ-027 SHALL place the OP encodings (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU) in the shared defs file, alongside the existing register constants.
REQ-028 SHALL be built as a single module holding the FSM and datapath.
- A shared accumulator/shift register serves both multiply and divide.
- No sub-module is required; the optional split is muldiv_ctrl, containing the FSM and counter.

Verification
REQ-029 SHALL cover MUL: A=0x0000_0007, B=0x0000_0006, OP=00 -> after 33 cycles DONE=1, WR=1, RESULT=0x0000_002A, AD_OUT=AD_IN.
REQ-030 SHALL cover MULHU: A=0xFFFF_FFFF, B=0xFFFF_FFFF, OP=01 -> RESULT=0xFFFF_FFFE; with OP=00 -> RESULT=0x0000_0001.
REQ-031 SHALL cover DIVU and REMU: A=100, B=7 -> DIVU RESULT=14; REMU RESULT=2.
REQ-032 SHALL cover divide by zero: A=0x1234_5678, B=0 -> DIVU 0xFFFF_FFFF; REMU 0x1234_5678.
REQ-033 SHALL cover START held high continuously with changing A/B -> only the first-captured operands are used; back-to-back results are separated by an IDLE cycle; exactly one DONE per operation.
REQ-034 SHALL cover RST_N pulsed low at cycle 10 of RUN -> BUSY=0 immediately; no DONE/WR until a new START; the next operation's result is correct.
